ccff_chain_loader: RTL

//  Drives the configuration flip-flop chain (ccff_head in, ccff_tail out) that threads the grid tiles.

---
 rtl/ccff_chain_loader.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serializes host bitstream words MSB-first into the
// configuration flip-flop chain. It can optionally recirculate the chain
// once to compare a CRC-8 of the read-back bits with a CRC-8 of the loaded bits.
module ccff_chain_loader #(
  parameter int         CHAIN_LEN = 4,
  parameter int         WORD_W    = 8,
  parameter logic [7:0] CRC_POLY  = 8'h07
) (
  input  logic                             prog_clk,
  input  logic                             prog_reset_n,
  input  logic                             start,
  input  logic                             verify,
  input  logic                             word_valid,
  input  logic [WORD_W-1:0]                word_data,
  output logic                             word_ready,
  output logic                             ccff_head,
  output logic                             chain_en,
  input  logic                             ccff_tail,
  output logic                             busy,
  output logic                             done,
  output logic                             verify_err,
  output logic [$clog2(CHAIN_LEN+1)-1:0]   bit_count
);

  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam int NWORDS    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int REM       = CHAIN_LEN % WORD_W;
  localparam int LAST_BITS = (REM == 0) ? WORD_W : REM;
  localparam int BL_W      = $clog2(WORD_W + 1);
  localparam int WT_W      = $clog2(NWORDS + 1);

  localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_M1   = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WT_W-1:0]  NW_C     = WT_W'(NWORDS);
  localparam logic [WT_W-1:0]  LAST_IDX = WT_W'(NWORDS - 1);
  localparam logic [BL_W-1:0]  FULL_BL  = BL_W'(WORD_W);
  localparam logic [BL_W-1:0]  LAST_BL  = BL_W'(LAST_BITS);
  localparam logic [BL_W-1:0]  ONE_BL   = BL_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VERIFY, S_DONE} state_t;

  state_t             state;
  logic               verify_lat;
  logic [WORD_W-1:0]  shift_reg;
  logic [BL_W-1:0]    bits_left;
  logic [WT_W-1:0]    words_taken;
  logic [7:0]         crc_ld;
  logic [7:0]         crc_rb;

  // One serial CRC-8 step, MSB-first feedback.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    return {c[6:0], 1'b0} ^ ((c[7] ^ b) ? CRC_POLY : 8'h00);
  endfunction

  // The chain advances while loaded bits remain (until the chain is full) and
  // on every VERIFY cycle; a word is taken when the register is empty or about
  // to empty, so back-to-back words shift without a bubble.
  assign chain_en   = ((state == S_LOAD) && (bits_left != '0) && (bit_count != LEN_C)) ||
                      (state == S_VERIFY);
  assign word_ready = (state == S_LOAD) &&
                      ((bits_left == '0) || ((bits_left == ONE_BL) && chain_en)) &&
                      (words_taken < NW_C);
  assign ccff_head  = (state == S_VERIFY) ? ccff_tail :
                      (state == S_LOAD)   ? shift_reg[WORD_W-1] : 1'b0;

  // Control FSM with the datapath registers it owns and registered status outputs.
  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state       <= S_IDLE;
      verify_lat  <= 1'b0;
      shift_reg   <= '0;
      bits_left   <= '0;
      words_taken <= '0;
      bit_count   <= '0;
      crc_ld      <= '0;
      crc_rb      <= '0;
      verify_err  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_LOAD;
            verify_lat  <= verify;
            bits_left   <= '0;
            words_taken <= '0;
            bit_count   <= '0;
            crc_ld      <= '0;
            crc_rb      <= '0;
            verify_err  <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end
        end
        S_LOAD: begin
          if (chain_en) begin
            shift_reg <= shift_reg << 1;
            bits_left <= bits_left - ONE_BL;
            bit_count <= bit_count + CNT_W'(1);
            crc_ld    <= crc_step(crc_ld, shift_reg[WORD_W-1]);
          end
          // A newly accepted word overrides the shift of the word just emptied;
          // the final word only contributes the bits the chain still needs.
          if (word_valid && word_ready) begin
            shift_reg   <= word_data;
            bits_left   <= (words_taken == LAST_IDX) ? LAST_BL : FULL_BL;
            words_taken <= words_taken + WT_W'(1);
          end
          if (bit_count == LEN_C) begin
            bits_left <= '0;
            if (verify_lat) begin
              state     <= S_VERIFY;
              bit_count <= '0;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        S_VERIFY: begin
          crc_rb    <= crc_step(crc_rb, ccff_tail);
          bit_count <= bit_count + CNT_W'(1);
          if (bit_count == LEN_M1) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            verify_err <= (crc_step(crc_rb, ccff_tail) != crc_ld);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
